uart_rx: RTL and testbench

- Serial UART receiver. It consumes the line driven by the team's uart_tx (tx_pin) and produces parallel bytes with status flags.
- Samples the line on an oversampled tick (default 16x baud), supplied by the same tick-generator style as the transmitter's baud_tick.
- Frame format matches uart_tx: 1 start bit (low), DATA_BITS data bits LSB first, optional even-parity bit, 1 stop bit (high).

---
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_rx.sv | 126 ++++++++++++
 tb/tb_uart_rx.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, sampling strobe, parity control and received-word status of the UART receiver.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 sample_tick;
    logic                 rx_pin;
    logic                 parity_enable;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_error;
    logic                 framing_error;
    logic                 rx_busy;
    modport master (
        output sample_tick, rx_pin, parity_enable,
        input  rx_data, rx_valid, parity_error, framing_error, rx_busy
    );
    modport slave (
        input  sample_tick, rx_pin, parity_enable,
        output rx_data, rx_valid, parity_error, framing_error, rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver, LSB-first data, optional even parity, one stop bit.
// Define UART_RX_MAJORITY_EN for a 3-sample majority vote around each mid-bit point.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
    state_t               state_q, state_d;
    logic [1:0]           sync_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d;
    logic                 pe_q, pe_d, pen_q, pen_d, perr_q, perr_d, ferr_q, ferr_d, valid_q, valid_d;
    logic                 rx_s, bit_v, bit_end;
    assign rx_s = sync_q[1];
`ifdef UART_RX_MAJORITY_EN
    // Every decision moves one tick later so the vote covers mid-1, mid and mid+1.
    localparam int MID = OVERSAMPLE / 2;
    logic [1:0] hist_q;
    always_ff @(posedge clk) begin
        if (reset)
            hist_q <= 2'b11;
        else if (bus.sample_tick)
            hist_q <= {hist_q[0], rx_s};
    end
    assign bit_v = (hist_q[1] & hist_q[0]) | ((hist_q[1] | hist_q[0]) & rx_s);
`else
    localparam int MID = OVERSAMPLE / 2 - 1;
    assign bit_v = rx_s;
`endif
    assign bit_end = cnt_q == CW'(OVERSAMPLE - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            pe_q    <= 1'b0;
            pen_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], bus.rx_pin};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            pe_q    <= pe_d;
            pen_q   <= pen_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            valid_q <= valid_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        data_d  = data_q;
        pe_d    = pe_q;
        pen_d   = pen_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        valid_d = 1'b0;
        if (bus.sample_tick) begin
            case (state_q)
                IDLE: if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                    pen_d   = bus.parity_enable;
                end
                START: if (cnt_q == CW'(MID)) begin
                    state_d = bit_v ? IDLE : DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                DATA: begin
                    cnt_d = bit_end ? '0 : cnt_q + CW'(1);
                    if (bit_end) begin
                        sh_d  = {bit_v, sh_q[DATA_BITS-1:1]};
                        idx_d = idx_q + IW'(1);
                        if (idx_q == IW'(DATA_BITS - 1))
                            state_d = pen_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    cnt_d = bit_end ? '0 : cnt_q + CW'(1);
                    if (bit_end) begin
                        pe_d    = bit_v ^ (^sh_q);
                        state_d = STOP;
                    end
                end
                STOP: begin
                    cnt_d = bit_end ? '0 : cnt_q + CW'(1);
                    if (bit_end) begin
                        data_d  = sh_q;
                        perr_d  = pen_q & pe_q;
                        ferr_d  = ~bit_v;
                        valid_d = 1'b1;
                        state_d = bit_v ? IDLE : BREAK;
                    end
                end
                BREAK: state_d = rx_s ? IDLE : BREAK;
                default: state_d = IDLE;
            endcase
        end
    end
    assign bus.rx_data       = data_q;
    assign bus.rx_valid      = valid_q;
    assign bus.parity_error  = perr_q;
    assign bus.framing_error = ferr_q;
    assign bus.rx_busy       = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a queue of expected words built from frame contents,
// checked every cycle, plus literal checks after each scenario.
module tb_uart_rx;
    logic clk = 1'b0;
    logic reset = 1'b1;
    uart_rx_if #(.DATA_BITS(8)) bus();
    uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (.clk(clk), .reset(reset), .bus(bus));
    typedef struct {logic [7:0] d; logic pe; logic fe;} exp_t;
    exp_t       q[$];
    exp_t       cur;
    int         checks = 0;
    int         passes = 0;
    int         vcount = 0;
    logic [7:0] m_data;
    logic       m_pe, m_fe;
    always #5 clk = ~clk;
    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got %0h, want %0h at %0t", n, act, exp, $time);
    endfunction
    initial begin
        bus.sample_tick = 1'b0;
        forever begin
            repeat (4) begin
                @(posedge clk);
                #1 bus.sample_tick = 1'b0;
            end
            @(posedge clk);
            #1 bus.sample_tick = 1'b1;
        end
    end
    always @(negedge clk) begin
        if (reset) begin
            m_data = 8'h00;
            m_pe   = 1'b0;
            m_fe   = 1'b0;
        end else begin
            if (bus.rx_valid) begin
                vcount++;
                if (q.size() == 0)
                    chk("unexpected_valid", bus.rx_valid, 0);
                else begin
                    cur    = q.pop_front();
                    m_data = cur.d;
                    m_pe   = cur.pe;
                    m_fe   = cur.fe;
                end
            end
            chk("rx_data", bus.rx_data, m_data);
            chk("parity_error", bus.parity_error, m_pe);
            chk("framing_error", bus.framing_error, m_fe);
        end
    end
    task automatic line(input logic b, input int n);
        bus.rx_pin = b;
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [7:0] d, input logic pen, input logic pbit, input logic stop,
                        input int nstop, input bit exp_it);
        if (exp_it)
            q.push_back('{d, pen & (pbit ^ (^d)), ~stop});
        bus.parity_enable = pen;
        line(1'b0, 80);
        for (int i = 0; i < 8; i++)
            line(d[i], 80);
        if (pen)
            line(pbit, 80);
        line(stop, 80 * nstop);
    endtask
    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!bus.sample_tick) @(posedge clk);
        end
        #1;
    endtask
    // Transmitter stand-in: one bit per 16 sample ticks, even parity always on.
    task automatic tx_byte(input logic [7:0] d);
        logic [10:0] fr;
        fr = {1'b1, ^d, d, 1'b0};
        q.push_back('{d, 1'b0, 1'b0});
        bus.parity_enable = 1'b1;
        for (int i = 0; i < 11; i++) begin
            bus.rx_pin = fr[i];
            wait_ticks(16);
        end
    endtask
    task automatic post(input string n, input logic [7:0] d, input logic pe, input logic fe, input int nv);
        chk({n, "_data"}, bus.rx_data, d);
        chk({n, "_perr"}, bus.parity_error, pe);
        chk({n, "_ferr"}, bus.framing_error, fe);
        chk({n, "_vcount"}, vcount, nv);
    endtask
    initial begin
        bus.rx_pin = 1'b1;
        bus.parity_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_data", bus.rx_data, 0);
        chk("rst_valid", bus.rx_valid, 0);
        chk("rst_perr", bus.parity_error, 0);
        chk("rst_ferr", bus.framing_error, 0);
        chk("rst_busy", bus.rx_busy, 0);
        line(1'b1, 40);
        send(8'h55, 1'b1, 1'b0, 1'b1, 1, 1'b1);
        post("even", 8'h55, 1'b0, 1'b0, 1);
        chk("even_busy", bus.rx_busy, 0);
        line(1'b1, 80);
        send(8'h55, 1'b1, 1'b1, 1'b1, 1, 1'b1);
        post("badpar", 8'h55, 1'b1, 1'b0, 2);
        line(1'b1, 80);
        send(8'h0F, 1'b1, 1'b0, 1'b1, 1, 1'b1);
        post("goodpar", 8'h0F, 1'b0, 1'b0, 3);
        line(1'b1, 80);
        send(8'hA5, 1'b0, 1'b0, 1'b0, 3, 1'b1);
        post("framing", 8'hA5, 1'b0, 1'b1, 4);
        chk("break_busy", bus.rx_busy, 1);
        line(1'b1, 80);
        chk("break_exit_busy", bus.rx_busy, 0);
        line(1'b1, 400);
        chk("break_no_frame", vcount, 4);
        line(1'b0, 15);
        chk("glitch_busy", bus.rx_busy, 1);
        line(1'b1, 65);
        chk("glitch_drop", bus.rx_busy, 0);
        line(1'b1, 200);
        chk("glitch_no_frame", vcount, 4);
        send(8'h3C, 1'b0, 1'b0, 1'b1, 1, 1'b1);
        send(8'hC3, 1'b0, 1'b0, 1'b1, 1, 1'b1);
        post("b2b", 8'hC3, 1'b0, 1'b0, 6);
        line(1'b1, 80);
        bus.parity_enable = 1'b0;
        line(1'b0, 80);
        for (int i = 0; i < 4; i++)
            line(1'b1, 80);
        line(1'b1, 40);
        chk("pre_rst_busy", bus.rx_busy, 1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_data", bus.rx_data, 0);
        chk("mid_rst_valid", bus.rx_valid, 0);
        chk("mid_rst_perr", bus.parity_error, 0);
        chk("mid_rst_ferr", bus.framing_error, 0);
        chk("mid_rst_busy", bus.rx_busy, 0);
        line(1'b1, 400);
        chk("mid_rst_no_frame", vcount, 6);
        send(8'h81, 1'b0, 1'b0, 1'b1, 1, 1'b1);
        post("after_rst", 8'h81, 1'b0, 1'b0, 7);
        line(1'b1, 80);
        tx_byte(8'h00);
        post("loop00", 8'h00, 1'b0, 1'b0, 8);
        wait_ticks(16);
        tx_byte(8'hFF);
        post("loopFF", 8'hFF, 1'b0, 1'b0, 9);
        wait_ticks(16);
        tx_byte(8'h5A);
        post("loop5A", 8'h5A, 1'b0, 1'b0, 10);
        line(1'b1, 160);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
